// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// Walks a LeNet-style network (C1, S2, C3, S4, C5) one layer at a time. For
// each enabled layer it sweeps the feature-BRAM rows 0..ROWS-1, then waits
// PIPE_LAT cycles for the conv datapath to drain. After that it moves to the
// next enabled layer. When the last enabled layer has drained it gives a
// one-cycle done pulse.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous reset, active low
//   start       run request, only looked at while idle
//   layer_mask  per-layer enable, bit 0 = C1 .. bit 4 = C5, captured on start
//   hold        stall; freezes sequencing while a run is in progress
//   rd_addr     feature BRAM row address
//   rd_valid    rd_addr is a live read this cycle
//   C1_en..C5_en one-hot layer enables, high through the sweep and the drain
//   layer_idx   current layer 0..4
//   busy        high while sweeping or draining
//   done        one-cycle completion pulse

module conv_layer_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int ROWS_C1  = 32,
    parameter int ROWS_S2  = 28,
    parameter int ROWS_C3  = 14,
    parameter int ROWS_S4  = 10,
    parameter int ROWS_C5  = 5,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        layer_mask,
    input  logic              hold,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              C1_en,
    output logic              S2_en,
    output logic              C3_en,
    output logic              S4_en,
    output logic              C5_en,
    output logic [2:0]        layer_idx,
    output logic              busy,
    output logic              done
);

    // The drain counter runs 0..PIPE_LAT-1. It is kept at least one bit wide.
    localparam int CNT_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        layer_q;
    logic [2:0]        layer_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_next;
    logic [4:0]        mask_q;
    logic [4:0]        mask_next;

    logic [ADDR_W-1:0] row_last;
    logic              first_found;
    logic [2:0]        first_layer;
    logic              next_found;
    logic [2:0]        next_layer;
    logic [4:0]        en_vec;

    // Last row address of the layer currently being swept.
    always_comb begin
        row_last = ADDR_W'(ROWS_C5 - 1);
        case (layer_q)
            3'd0:    row_last = ADDR_W'(ROWS_C1 - 1);
            3'd1:    row_last = ADDR_W'(ROWS_S2 - 1);
            3'd2:    row_last = ADDR_W'(ROWS_C3 - 1);
            3'd3:    row_last = ADDR_W'(ROWS_S4 - 1);
            default: row_last = ADDR_W'(ROWS_C5 - 1);
        endcase
    end

    // Priority search for the lowest enabled layer. first_* searches the live
    // mask so a run can start directly. next_* searches the captured mask for
    // layers above the current one. Skipped layers therefore cost no cycles.
    always_comb begin
        first_found = 1'b0;
        first_layer = 3'd0;
        next_found  = 1'b0;
        next_layer  = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (layer_mask[i]) begin
                first_found = 1'b1;
                first_layer = 3'(i);
            end
            if (mask_q[i] && (i > int'(layer_q))) begin
                next_found = 1'b1;
                next_layer = 3'(i);
            end
        end
    end

    // State register. Reset clears everything, including mid-run, so that a
    // fresh start is needed before any further sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            layer_q <= 3'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= 5'd0;
        end else begin
            state   <= state_next;
            layer_q <= layer_next;
            addr_q  <= addr_next;
            cnt_q   <= cnt_next;
            mask_q  <= mask_next;
        end
    end

    // Next-state logic. hold only matters in RUN and DRAIN, where it freezes
    // the address, the drain count and the layer.
    always_comb begin
        state_next = state;
        layer_next = layer_q;
        addr_next  = addr_q;
        cnt_next   = cnt_q;
        mask_next  = mask_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mask_next = layer_mask;
                    addr_next = '0;
                    cnt_next  = '0;
                    if (first_found) begin
                        state_next = RUN;
                        layer_next = first_layer;
                    end else begin
                        state_next = DONE;
                        layer_next = 3'd0;
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    if (addr_q == row_last) begin
                        // Leave rd_addr on the last row; it is held through the drain.
                        state_next = DRAIN;
                        cnt_next   = '0;
                    end else begin
                        addr_next = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!hold) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_next = '0;
                        if (next_found) begin
                            state_next = RUN;
                            layer_next = next_layer;
                            addr_next  = '0;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        cnt_next = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                layer_next = 3'd0;
                addr_next  = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode directly from the registers. rd_valid is also gated by
    // hold in the same cycle, so a stalled cycle never issues a read.
    always_comb begin
        busy      = (state == RUN) || (state == DRAIN);
        rd_valid  = (state == RUN) && !hold;
        done      = (state == DONE);
        rd_addr   = addr_q;
        layer_idx = layer_q;
        en_vec    = busy ? (5'b00001 << layer_q) : 5'b00000;
        C1_en     = en_vec[0];
        S2_en     = en_vec[1];
        C3_en     = en_vec[2];
        S4_en     = en_vec[3];
        C5_en     = en_vec[4];
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer
// Scoreboard bench for conv_layer_sequencer. When a run is accepted, the
// reference model expands the mask into the ordered list of (layer, row)
// reads plus a final done marker. It also counts the unstalled work cycles
// the run needs: ROWS + PIPE_LAT for each enabled layer. A monitor on the
// falling edge pops the list whenever the DUT presents a read or done, and
// checks busy/done against the work counter every cycle.
//
// Ports: none (top-level bench).

module tb_conv_layer_sequencer;

    localparam int ADDR_W   = 6;
    localparam int PIPE_LAT = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [4:0]        layer_mask;
    logic              hold;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              C1_en;
    logic              S2_en;
    logic              C3_en;
    logic              S4_en;
    logic              C5_en;
    logic [2:0]        layer_idx;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int layer;
        int addr;
        bit is_done;
    } exp_t;

    typedef enum int {M_IDLE, M_WORK, M_DONE} mphase_t;

    exp_t    exp_q[$];
    mphase_t m_phase = M_IDLE;
    int      work_left = 0;

    conv_layer_sequencer #(
        .ADDR_W   (ADDR_W),
        .ROWS_C1  (32),
        .ROWS_S2  (28),
        .ROWS_C3  (14),
        .ROWS_S4  (10),
        .ROWS_C5  (5),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .layer_mask (layer_mask),
        .hold       (hold),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .C1_en      (C1_en),
        .S2_en      (S2_en),
        .C3_en      (C3_en),
        .S4_en      (S4_en),
        .C5_en      (C5_en),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rows_of(input int l);
        case (l)
            0:       return 32;
            1:       return 28;
            2:       return 14;
            3:       return 10;
            default: return 5;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_addr"}, int'(rd_addr), 0);
        checkOutput({tag, "_rd_valid"}, int'(rd_valid), 0);
        checkOutput({tag, "_enables"}, int'({C5_en, S4_en, C3_en, S2_en, C1_en}), 0);
        checkOutput({tag, "_layer_idx"}, int'(layer_idx), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    // Reference model: the whole run is a flat list of reads plus a done
    // marker, and it lasts a known number of unstalled cycles.
    always @(posedge clk or negedge rst) begin : model
        int units;
        if (!rst) begin
            m_phase   = M_IDLE;
            work_left = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if (start) begin
                        units = 0;
                        for (int l = 0; l < 5; l++) begin
                            if (layer_mask[l]) begin
                                units += rows_of(l) + PIPE_LAT;
                                for (int a = 0; a < rows_of(l); a++)
                                    exp_q.push_back('{l, a, 1'b0});
                            end
                        end
                        exp_q.push_back('{0, 0, 1'b1});
                        work_left = units;
                        m_phase   = (units > 0) ? M_WORK : M_DONE;
                    end
                end
                M_WORK: begin
                    if (!hold) begin
                        work_left--;
                        if (work_left == 0)
                            m_phase = M_DONE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Monitor: per-cycle busy/done against the model, plus pop-and-compare of
    // every read and done the DUT presents.
    always @(negedge clk) begin : monitor
        logic [4:0] en_vec;
        int         pending;
        exp_t       item;
        en_vec = {C5_en, S4_en, C3_en, S2_en, C1_en};
        checkOutput("busy", int'(busy), (m_phase == M_WORK) ? 1 : 0);
        checkOutput("done", int'(done), (m_phase == M_DONE) ? 1 : 0);
        if (m_phase != M_WORK) begin
            checkOutput("idle_enables", int'(en_vec), 0);
            checkOutput("idle_rd_valid", int'(rd_valid), 0);
        end else begin
            checkOutput("busy_enable_onehot", int'(en_vec), 1 << layer_idx);
        end
        if (hold)
            checkOutput("rd_valid_under_hold", int'(rd_valid), 0);
        if (rd_valid) begin
            pending = 0;
            if (exp_q.size() > 0)
                pending = exp_q[0].is_done ? 0 : 1;
            checkOutput("read_pending", pending, 1);
            if (pending == 1) begin
                item = exp_q.pop_front();
                checkOutput("read_layer", int'(layer_idx), item.layer);
                checkOutput("read_addr", int'(rd_addr), item.addr);
                checkOutput("read_enable", int'(en_vec), 1 << item.layer);
            end
        end
        if (done) begin
            pending = 0;
            if (exp_q.size() > 0)
                pending = exp_q[0].is_done ? 1 : 0;
            checkOutput("done_pending", pending, 1);
            if (pending == 1)
                item = exp_q.pop_front();
        end
    end

    // Issues one start and runs until the DUT reports done (bounded).
    // noise: random hold, mask churn, start pulses while busy and in DONE.
    task automatic applyStimulus(input logic [4:0] mask, input int hold_at, input int hold_len,
                                 input bit noise, input bit hold_at_start, input int exp_cycle);
        int cyc;
        bit finished;
        @(posedge clk); #1;
        start      = 1'b1;
        layer_mask = mask;
        hold       = hold_at_start;
        cyc        = 0;
        finished   = 1'b0;
        while (!finished && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (noise) begin
                start      = (m_phase == M_DONE) ? 1'b1
                           : ((m_phase == M_WORK) && ($urandom_range(0, 3) == 0));
                hold       = ($urandom_range(0, 4) == 0);
                layer_mask = 5'($urandom);
            end else begin
                start = 1'b0;
                hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
            end
            @(negedge clk);
            if (done)
                finished = 1'b1;
        end
        checkOutput("done_seen", int'(finished), 1);
        if (exp_cycle > 0 && finished)
            checkOutput("done_cycle", cyc, exp_cycle);
        #1;
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        hold       = 1'b0;
        layer_mask = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("por");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        $display("[TB] full network, no hold");
        applyStimulus(5'b11111, 0, 0, 1'b0, 1'b0, 100);
        $display("[TB] C3 only");
        applyStimulus(5'b00100, 0, 0, 1'b0, 1'b0, 17);
        $display("[TB] empty mask, hold in idle and done");
        applyStimulus(5'b00000, 1, 1, 1'b0, 1'b1, 1);
        $display("[TB] hold for 3 cycles at C1 row 10");
        applyStimulus(5'b11111, 11, 3, 1'b0, 1'b0, 103);
        $display("[TB] randomized runs with hold, mask churn and stray starts");
        applyStimulus(5'b11111, 0, 0, 1'b1, 1'b0, 0);
        for (int r = 0; r < 8; r++)
            applyStimulus(5'($urandom), 0, 0, 1'b1, 1'b0, 0);

        $display("[TB] reset during C3 sweep");
        @(posedge clk); #1;
        start      = 1'b1;
        layer_mask = 5'b11111;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            layer_mask = 5'($urandom);
        end
        @(negedge clk);
        checkOutput("pre_reset_layer", int'(layer_idx), 2);
        checkOutput("pre_reset_addr", int'(rd_addr), 5);
        #1;
        rst   = 1'b0;
        start = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        applyStimulus(5'b11111, 0, 0, 1'b0, 1'b0, 100);

        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the feature-BRAM row-address width.
REQ-002 Parameters ROWS_C1/ROWS_S2/ROWS_C3/ROWS_S4/ROWS_C5, defaults 32/28/14/10/5, SHALL set the rows swept per layer; each is 1..2^ADDR_W.
REQ-003 Parameter PIPE_LAT, default 2 (>=1), SHALL set the conv datapath drain cycles per layer.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  run request, sampled only in IDLE.
REQ-007 layer_mask  in  5  per-layer run enable [0]=C1..[4]=C5, captured when start is accepted.
REQ-008 hold  in  1  stall, e.g. BRAM load in progress; freezes sequencing.
REQ-009 rd_addr  out  ADDR_W  feature BRAM row address.
REQ-010 rd_valid  out  1  rd_addr is a live read this cycle.
REQ-011 C1_en, S2_en, C3_en, S4_en, C5_en  out  1 each  one-hot layer enables.
REQ-012 layer_idx  out  3  current layer 0..4.
REQ-013 busy  out  1  high in RUN and DRAIN.
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE with start=1 SHALL capture layer_mask and go next cycle to RUN at the lowest enabled layer, rd_addr=0; if the mask is 0, go to DONE.
REQ-017 RUN SHALL drive rd_valid=1 and exactly one layer enable, the enable matching layer_idx.
REQ-018 RUN SHALL increment rd_addr by 1 per unstalled cycle.
REQ-019 RUN with rd_addr==ROWS_<layer>-1 and unstalled SHALL go to DRAIN next cycle.
REQ-020 DRAIN SHALL drive rd_valid=0, keep the layer enable high and hold rd_addr.
REQ-021 DRAIN SHALL count PIPE_LAT unstalled cycles, then go to RUN at the next enabled layer with rd_addr=0, or to DONE if none remain.
REQ-022 DONE SHALL last one cycle with done=1, busy=0, all enables 0, then return to IDLE.
REQ-023 hold=1 in RUN/DRAIN SHALL freeze the state, rd_addr, drain counter and enables; rd_valid SHALL be 0 while hold=1.
REQ-024 hold has no effect in IDLE or DONE.
REQ-025 start SHALL be ignored outside IDLE, including DONE.
REQ-026 layer_mask changes after capture SHALL be ignored until the next accepted start.
REQ-027 rd_addr SHALL never exceed ROWS_<layer>-1; no wrap occurs.
REQ-028 Per-layer time with no hold SHALL be ROWS_<layer>+PIPE_LAT cycles.
REQ-029 Skipped layers SHALL cost zero cycles.

Reset
REQ-030 rst=0 SHALL immediately force IDLE and set rd_addr=0, rd_valid=0, all enables 0, layer_idx=0, busy=0, done=0 and the drain counter to 0, including mid-run.
REQ-031 After rst release, operation SHALL resume only on a fresh start.

Verification
REQ-032 Defaults, mask=5'b11111, start pulsed at edge 0, no hold -> C1_en cycles 1-34 (rd_addr 0..31 in cycles 1-32), S2_en cycles 35-64, C3_en cycles 65-80, S4_en cycles 81-92, C5_en cycles 93-99, done=1 in cycle 100 only.
REQ-033 mask=5'b00100 -> only C3_en; rd_addr 0..13 in cycles 1-14, drain cycles 15-16, done in cycle 17.
REQ-034 hold=1 for 3 cycles while rd_addr=10 in C1 -> rd_addr stays 10 and rd_valid=0 for those 3 cycles; done shifts to cycle 103.
REQ-035 mask=0 with start -> done=1 in cycle 1; busy and all enables stay 0.
REQ-036 rst asserted in C3 RUN -> all outputs 0 asynchronously; a start pulse held during rst is ignored; a later start restarts from C1 with rd_addr=0.
REQ-037 start pulsed during RUN and during DONE -> no effect; exactly one done pulse per accepted start.
